// File: rtl/alu_muldiv_unit.sv
// Execute-stage unit: single-cycle RV32I ALU ops plus an iterative 1-bit/cycle
// RV32M multiply/divide engine, with valid/ready on both the request and result sides.
module alu_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_1,
    input  logic [XLEN-1:0] in_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_XOR    = 5'd2,
        OP_OR     = 5'd3,
        OP_AND    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } op_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic [SHW-1:0]  counter_q, counter_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;

    logic accept;
    assign in_ready    = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept      = in_valid & in_ready;
    assign out_valid   = (state_q == S_DONE);
    assign out_result  = result_q;
    assign out_illegal = illegal_q;
    assign busy        = (state_q == S_CALC);

    // Request decode and single-cycle ALU path
    logic            is_m_op, is_div_op, is_legal, div_zero, div_ovf;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, alu_res;
    logic [SHW-1:0]  shamt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        alu_res = '0;
        shamt   = in_2[SHW-1:0];
        case (in_op)
            OP_ADD:  alu_res = in_1 + in_2;
            OP_SUB:  alu_res = in_1 - in_2;
            OP_XOR:  alu_res = in_1 ^ in_2;
            OP_OR:   alu_res = in_1 | in_2;
            OP_AND:  alu_res = in_1 & in_2;
            OP_SLL:  alu_res = in_1 << shamt;
            OP_SRL:  alu_res = in_1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(in_1) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_1) < $signed(in_2)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, in_1 < in_2};
            default: alu_res = '0;
        endcase
    end

    assign is_m_op   = (in_op >= OP_MUL) && (in_op <= OP_REMU);
    assign is_div_op = (in_op >= OP_DIV) && (in_op <= OP_REMU);
    assign is_legal  = (in_op <= OP_REMU) && (MULDIV_EN || !is_m_op);
    assign div_zero  = is_div_op && (in_2 == '0);
    assign div_ovf   = ((in_op == OP_DIV) || (in_op == OP_REM)) && (in_1 == SMIN) && (in_2 == '1);

    // Engine works on magnitudes; signs are re-applied when the last iteration retires
    assign a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU) || (in_op == OP_DIV) || (in_op == OP_REM);
    assign b_signed = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
    assign a_neg    = a_signed & in_1[XLEN-1];
    assign b_neg    = b_signed & in_2[XLEN-1];
    assign a_mag    = a_neg ? -in_1 : in_1;
    assign b_mag    = b_neg ? -in_2 : in_2;

    // One engine step: shift-add for multiply, restoring shift-subtract for divide
    logic            op_is_mul;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] hi_step, lo_step;

    assign op_is_mul = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = (div_shift >= {1'b0, b_q});

    always_comb begin
        if (op_is_mul) begin
            {hi_step, lo_step} = {mul_sum, lo_q[XLEN-1:1]};
        end else begin
            hi_step = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], div_ge};
        end
    end

    logic [2*XLEN-1:0] prod_raw, prod_fix;
    logic [XLEN-1:0]   final_res;

    assign prod_raw = {hi_step, lo_step};
    assign prod_fix = neg_q ? -prod_raw : prod_raw;

    always_comb begin
        case (op_q)
            OP_MUL:                        final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_res = neg_q ? -lo_step : lo_step;
            default:                       final_res = rem_neg_q ? -hi_step : hi_step;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        counter_d = counter_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;

        case (state_q)
            S_CALC: begin
                hi_d      = hi_step;
                lo_d      = lo_step;
                counter_d = counter_q - 1'b1;
                if (counter_q == '0) begin
                    state_d   = S_DONE;
                    result_d  = final_res;
                    illegal_d = 1'b0;
                    counter_d = '0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            op_d      = in_op;
            illegal_d = !is_legal;
            state_d   = S_DONE;
            if (!is_legal) begin
                result_d = '0;
            end else if (!is_m_op) begin
                result_d = alu_res;
            end else if (div_zero) begin
                result_d = ((in_op == OP_DIV) || (in_op == OP_DIVU)) ? '1 : in_1;
            end else if (div_ovf) begin
                result_d = (in_op == OP_DIV) ? in_1 : '0;
            end else begin
                state_d   = S_CALC;
                counter_d = SHW'(XLEN - 1);
                hi_d      = '0;
                lo_d      = is_div_op ? a_mag : b_mag;
                b_d       = is_div_op ? b_mag : a_mag;
                neg_d     = a_neg ^ b_neg;
                rem_neg_d = a_neg;
            end
        end

        // Abort wins over both a new accept and an engine completion
        if (flush) begin
            state_d   = S_IDLE;
            counter_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
            counter_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            counter_q <= counter_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed self-checking bench for alu_muldiv_unit at XLEN=32 with hand-computed vectors.
module tb_alu_muldiv_unit;

    localparam int XLEN = 32;

    localparam logic [4:0] ADD = 5'd0, SLL = 5'd5, SRA = 5'd7, SLT = 5'd8, SLTU = 5'd9;
    localparam logic [4:0] MUL = 5'd10, MULH = 5'd11, MULHSU = 5'd12, MULHU = 5'd13;
    localparam logic [4:0] DIV = 5'd14, DIVU = 5'd15, REM = 5'd16, REMU = 5'd17;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal, busy;
    logic [4:0]      in_op;
    logic [XLEN-1:0] in_1, in_2, out_result;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.XLEN(XLEN), .MULDIV_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_1        (in_1),
        .in_2        (in_2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Present one request, let the next edge accept it, then scramble the inputs
    task automatic issue(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_1     = a;
        in_2     = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op    = ADD;
        in_1     = 32'hA5A5_5A5A;
        in_2     = 32'h0F0F_F0F0;
    endtask

    task automatic wait_result(output int lat, output int busy_cyc);
        lat      = 1;
        busy_cyc = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat,
                          input logic exp_ill);
        int lat, bc;
        issue(op, a, b);
        wait_result(lat, bc);
        check(tag, out_result, exp);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, bc, seen;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = ADD;
        in_1 = '0; in_2 = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_illegal", {31'd0, out_illegal}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU ops
        run_op("ADD", ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, 1'b0);
        run_op("SRA", SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 1'b0);
        run_op("SLT", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b0);
        run_op("SLTU", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0);
        run_op("SLL", SLL, 32'd1, 32'd33, 32'd2, 1, 1'b0);

        // MUL family, with latency and busy-length measured on the first
        issue(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(lat, bc);
        check("MUL", out_result, 32'd1);
        check("MUL latency", lat, 32'd33);
        check("MUL busy cycles", bc, 32'd32);
        run_op("MULHU", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("MULH", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
        run_op("MULHSU", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);

        // Division
        run_op("DIV", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("REM", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("DIVU", DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        run_op("REMU", REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);

        // Special cases on the fast path
        run_op("DIV by zero", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("REMU by zero", REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        run_op("DIV overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run_op("REM overflow", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);

        // Backpressure: result must hold and the unit must refuse new work
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(DIVU, 32'd100, 32'd7);
        wait_result(lat, bc);
        check("bp DIVU result", out_result, 32'd14);
        check("bp DIVU latency", lat, 32'd33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp held result", out_result, 32'd14);
            check("bp held out_valid", {31'd0, out_valid}, 32'd1);
            check("bp in_ready low", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_op    = ADD;
            in_1     = 32'(k * 16 + 1);
            in_2     = 32'd100;
            @(posedge clk); #1;
            check("stream out_valid", {31'd0, out_valid}, 32'd1);
            check("stream result", out_result, 32'(k * 16 + 101));
        end
        in_valid = 1'b0;

        // Flush ten cycles into a divide
        issue(DIV, 32'hFFFF_FF9C, 32'd7);
        seen = 0;
        repeat (9) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if (out_valid === 1'b1) seen++;
        check("flush no valid seen", seen, 32'd0);
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        check("flush busy", {31'd0, busy}, 32'd0);
        run_op("ADD after flush", ADD, 32'd2, 32'd3, 32'd5, 1, 1'b0);

        // Asynchronous reset in the middle of a multiply
        issue(MUL, 32'hFFFF_FFFF, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        check("mid-MUL busy", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async rst out_valid", {31'd0, out_valid}, 32'd0);
        check("async rst out_result", out_result, 32'd0);
        check("async rst out_illegal", {31'd0, out_illegal}, 32'd0);
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst in_ready", {31'd0, in_ready}, 32'd1);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op("ADD after rst", ADD, 32'd2, 32'd3, 32'd5, 1, 1'b0);
        run_op("illegal op 20", 5'd20, 32'd9, 32'd9, 32'd0, 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
